data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised, byte-addressed, little-endian data memory for the CPU datapath. It serves
//  LD/SD of byte/half/word/double size with sign/zero extension and a valid/ready request
//  and response handshake. Storage is synchronous. Out-of-range accesses (and misaligned
//  ones, when enabled) return an error instead of aliasing. Sits between the MEM stage and storage.
// PARAMETERS
//  XLEN          64   data width in bits; fixed at 64, the largest access is one double (8 B)
//  DEPTH_BYTES   256  number of byte locations
//  MISALIGN_ERR  0    1: a non-naturally-aligned access errors; 0: it is allowed
//  INIT_PATTERN  1    1: mem[i]=(i+1)&8'hFF at time zero; 0: mem[i]=0 at time zero
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     synchronous reset, active low
//  req_valid    in   1     request present
//  req_ready    out  1     controller can accept a request
//  req_we       in   1     1=store, 0=load
//  req_size     in   2     00=B 01=H 10=W 11=D
//  req_unsigned in   1     load only: zero-extend if 1, sign-extend if 0
//  req_addr     in   64    byte address
//  req_wdata    in   XLEN  store data, low (1<<size) bytes used
//  rsp_valid    out  1     response present
//  rsp_ready    in   1     consumer takes the response
//  rsp_rdata    out  XLEN  extended load data; 0 for stores and errors
//  rsp_err      out  1     range or alignment fault
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (clk, rst_n).
//  - Reset outputs: req_ready=0 while rst_n=0, then 1 in IDLE; rsp_valid=0, rsp_rdata=0,
//    rsp_err=0; FSM goes to IDLE. Array contents are NOT reset.
//  - FSM: IDLE -> (accept, load, no err) ACCESS -> RESP; IDLE -> (accept, store or err) RESP;
//    RESP -> (rsp_ready) IDLE.
//  - Accept = req_valid && req_ready. req_ready = (state==IDLE) && rst_n.
//  - N = 1<<req_size. err = (req_addr + N > DEPTH_BYTES), evaluated in 65-bit arithmetic so a
//    wrap is caught; or (MISALIGN_ERR && req_addr % N != 0).
//  - Store: on the accept edge, write bytes addr..addr+N-1 <= wdata[8N-1:0], LSB first.
//    The response follows 1 cycle later with rdata=0 and err=0.
//  - Load: the array is read on the accept edge. ACCESS registers the extended data.
//    rsp_valid is asserted 2 cycles after accept.
//  - Error: no array write. The response follows 1 cycle later with err=1 and rdata=0.
//  - Extension: bit 8N-1 is replicated to bit XLEN-1 unless req_unsigned. A D-size load ignores req_unsigned.
//  - RESP holds rsp_* stable until rsp_ready. It may complete in the first RESP cycle.
//    req_ready stays low throughout, so at most one request is outstanding.
//  - Read-after-write: a load accepted after a store's response sees the stored data.
//  - Reset mid-operation drops the in-flight response. A store is already committed only if
//    its accept edge preceded reset.
// STRUCTURE
//  - dmem_pkg holds:
//    - the size encodings SZ_B/SZ_H/SZ_W/SZ_D;
//    - the state enum IDLE/ACCESS/RESP;
//    - the function sext(data, size, unsigned).
//  - Sub-module dmem_byte_array(clk, we, be[7:0], addr, wdata, rdata): DEPTH_BYTES x 8 storage.
//    It has a registered 8-byte read window and per-lane write enables, and applies INIT_PATTERN.
//  - The top level holds the FSM, the range/alignment check, lane steering, extension and the response regs.
// TESTING (DEPTH_BYTES=256, INIT_PATTERN=1, MISALIGN_ERR=0 unless stated)
//  1. Load D @0x00 -> rsp_valid 2 cycles after accept, rdata=0x0807060504030201, err=0.
//  2. Load B @0x7F, signed -> 0xFFFFFFFFFFFFFF80; same load unsigned -> 0x0000000000000080.
//  3. Store W 0xDEADBEEF @0x10, then load W signed @0x10 -> 0xFFFFFFFFDEADBEEF.
//     Load B @0x14 -> 0x15 (neighbour untouched).
//  4. Load H @0x03 -> 0x0504. With MISALIGN_ERR=1, same load -> err=1, rdata=0.
//  5. Store D @0xFC and load B @0xFFFF_FFFF_FFFF_FFFF -> err=1 for both.
//     Reading 0x00..0x07 afterwards still gives pattern 01..08 (no wrap write).
//  6. Hold rsp_ready=0 for 3 cycles after a load -> rsp_* stable, req_ready=0.
//     Pull rst_n low in RESP -> next cycle rsp_valid=0, state IDLE, earlier stores retained.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, controller states and load-extension helper
package dmem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  function automatic logic [63:0] sext(input logic [63:0] d, input logic [1:0] size, input logic uns);
    return size == SZ_D ? d :
           size == SZ_W ? {{32{d[31] & ~uns}}, d[31:0]} :
           size == SZ_H ? {{48{d[15] & ~uns}}, d[15:0]} :
                          {{56{d[7] & ~uns}}, d[7:0]};
  endfunction
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: byte storage with per-lane write enables and a registered 8-byte read window
module dmem_byte_array #(
  parameter int DEPTH_BYTES  = 256,
  parameter bit INIT_PATTERN = 1,
  parameter int AW           = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  function automatic logic [8*DEPTH_BYTES-1:0] init_image();
    logic [8*DEPTH_BYTES-1:0] img;
    for (int i = 0; i < DEPTH_BYTES; i++) img[8*i +: 8] = INIT_PATTERN ? 8'(i + 1) : 8'h00;
    return img;
  endfunction
  logic [8*DEPTH_BYTES-1:0] mem_q = init_image();
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (we && be[k] && int'(addr) + k < DEPTH_BYTES) mem_q[8*(int'(addr) + k) +: 8] <= wdata[8*k +: 8];
      rdata[8*k +: 8] <= int'(addr) + k < DEPTH_BYTES ? mem_q[8*(int'(addr) + k) +: 8] : 8'h00;
    end
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed little-endian data memory with valid/ready request and response
module data_memory_ctrl import dmem_pkg::*; #(
  parameter int XLEN         = 64,
  parameter int DEPTH_BYTES  = 256,
  parameter bit MISALIGN_ERR = 0,
  parameter bit INIT_PATTERN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [63:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int AW = $clog2(DEPTH_BYTES) + 1;
  state_e      state_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [63:0] rsp_rdata_q;
  logic [64:0] n;
  logic [7:0]  be;
  logic [63:0] win;
  logic        err;
  logic        accept;
  logic        we;
  assign req_ready = state_q == IDLE && rst_n;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  always_comb begin
    n      = 65'd1 << req_size;
    accept = req_valid && req_ready;
    err    = ({1'b0, req_addr} + n > 65'(DEPTH_BYTES)) ||
             (MISALIGN_ERR && (req_addr & (n[63:0] - 64'd1)) != 64'd0);
    be     = req_size == SZ_B ? 8'h01 : req_size == SZ_H ? 8'h03 : req_size == SZ_W ? 8'h0F : 8'hFF;
    we     = accept && req_we && !err;
  end
  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES), .INIT_PATTERN(INIT_PATTERN), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .addr  (req_addr[AW-1:0]),
    .wdata (req_wdata),
    .rdata (win)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          size_q      <= req_size;
          uns_q       <= req_unsigned;
          state_q     <= !req_we && !err ? ACCESS : RESP;
          rsp_valid_q <= req_we || err;
          rsp_err_q   <= err;
          rsp_rdata_q <= '0;
        end
        ACCESS: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= sext(win, size_q, uns_q);
        end
        RESP: if (rsp_ready) begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
